// File: rtl/pipe_pkg.sv
// Shared types and helpers for the elastic pipeline register.
package pipe_pkg;

    // Occupancy state of one skid stage.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

    // Width needed to count every beat a chain of `stages` slots can hold.
    function automatic int cnt_w(input int stages);
        return $clog2(2 * stages + 1);
    endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// One elastic stage: main register drives the output, skid register catches
// the beat that arrives while the output is stalled. In-ready depends only on
// the registered state, so downstream back-pressure never reaches upstream
// combinationally.
module pipe_skid_slot
    import pipe_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_flush,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data,
    output logic [1:0]   o_occ
);

    skid_state_e  state_p0;
    skid_state_e  state_nxt;
    logic [W-1:0] main_p0;
    logic [W-1:0] skid_p0;
    logic         load_main;
    logic         load_skid;
    logic         main_from_skid;

    // State register; reset leaves the stage empty.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_p0 <= EMPTY;
        end else begin
            state_p0 <= state_nxt;
        end
    end

    // Next state and data-path steering; flush overrides every transfer.
    always_comb begin
        state_nxt      = state_p0;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state_p0)
            EMPTY: begin
                if (i_valid) begin
                    state_nxt = BUSY;
                    load_main = 1'b1;
                end
            end
            BUSY: begin
                if (i_valid && i_ready) begin
                    load_main = 1'b1;
                end else if (i_valid) begin
                    state_nxt = FULL;
                    load_skid = 1'b1;
                end else if (i_ready) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (i_ready) begin
                    state_nxt      = BUSY;
                    main_from_skid = 1'b1;
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
        if (i_flush) begin
            state_nxt      = EMPTY;
            load_main      = 1'b0;
            load_skid      = 1'b0;
            main_from_skid = 1'b0;
        end
    end

    // Main and skid data registers; contents survive a flush untouched.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            main_p0 <= '0;
            skid_p0 <= '0;
        end else begin
            if (load_main) begin
                main_p0 <= i_data;
            end else if (main_from_skid) begin
                main_p0 <= skid_p0;
            end
            if (load_skid) begin
                skid_p0 <= i_data;
            end
        end
    end

    assign o_ready = (state_p0 != FULL);
    assign o_valid = (state_p0 != EMPTY);
    assign o_data  = main_p0;
    assign o_occ   = (state_p0 == FULL) ? 2'd2 :
                     (state_p0 == BUSY) ? 2'd1 : 2'd0;

endmodule

// File: rtl/pipe_reg_elastic.sv
// Elastic pipeline register: STAGES cascaded skid slots carrying NUM_CH
// channels of DATA_W bits as one beat, with registered upstream ready.
module pipe_reg_elastic
    import pipe_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 2,
    parameter int STAGES = 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [NUM_CH*DATA_W-1:0]     i_data,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [NUM_CH*DATA_W-1:0]     o_data,
    input  logic                         i_flush,
    output logic [cnt_w(STAGES)-1:0]     o_count
);

    localparam int W     = NUM_CH * DATA_W;
    localparam int CNT_W = cnt_w(STAGES);

    // vld/dat index n is the input of slot n; index STAGES is the block output.
    logic [STAGES:0] vld;
    logic [STAGES:0] rdy;
    logic [W-1:0]    dat [STAGES+1];
    logic [1:0]      occ [STAGES];

    assign vld[0]      = i_valid;
    assign dat[0]      = i_data;
    assign rdy[STAGES] = i_ready;
    assign o_ready     = rdy[0];
    assign o_valid     = vld[STAGES];
    assign o_data      = dat[STAGES];

    for (genvar n = 0; n < STAGES; n++) begin : g_stage
        pipe_skid_slot #(
            .W(W)
        ) u_slot (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_flush (i_flush),
            .i_valid (vld[n]),
            .o_ready (rdy[n]),
            .i_data  (dat[n]),
            .o_valid (vld[n+1]),
            .i_ready (rdy[n+1]),
            .o_data  (dat[n+1]),
            .o_occ   (occ[n])
        );
    end

    // Total beats held across the chain.
    always_comb begin
        o_count = '0;
        for (int n = 0; n < STAGES; n++) begin
            o_count = o_count + CNT_W'(occ[n]);
        end
    end

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Bench for pipe_reg_elastic: three configurations, directed scenarios and
// randomized valid/ready traffic checked against a FIFO-queue reference.
module tb_pipe_reg_elastic;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        v   [3];
    logic        r   [3];
    logic        fl  [3];
    logic [47:0] din [3];
    logic        ov  [3];
    logic        ordy[3];
    logic [47:0] od  [3];
    logic [47:0] cnt [3];

    logic        ov0, ov1, ov2, rd0, rd1, rd2;
    logic [15:0] od0, od1;
    logic [47:0] od2;
    logic [1:0]  c0;
    logic [2:0]  c1, c2;

    int checks  = 0;
    int errors  = 0;
    int ndrained = 0;
    logic [47:0] sb[$];
    bit          hold_pend = 0;
    logic [47:0] hold_data = '0;
    bit          last_acc = 0;

    always #5 clk = ~clk;

    pipe_reg_elastic #(.DATA_W(8), .NUM_CH(2), .STAGES(1)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v[0]), .o_ready(rd0),
        .i_data(din[0][15:0]), .o_valid(ov0), .i_ready(r[0]), .o_data(od0),
        .i_flush(fl[0]), .o_count(c0));
    pipe_reg_elastic #(.DATA_W(8), .NUM_CH(2), .STAGES(2)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v[1]), .o_ready(rd1),
        .i_data(din[1][15:0]), .o_valid(ov1), .i_ready(r[1]), .o_data(od1),
        .i_flush(fl[1]), .o_count(c1));
    pipe_reg_elastic #(.DATA_W(16), .NUM_CH(3), .STAGES(3)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v[2]), .o_ready(rd2),
        .i_data(din[2]), .o_valid(ov2), .i_ready(r[2]), .o_data(od2),
        .i_flush(fl[2]), .o_count(c2));

    assign ov[0] = ov0;  assign ov[1] = ov1;  assign ov[2] = ov2;
    assign ordy[0] = rd0; assign ordy[1] = rd1; assign ordy[2] = rd2;
    assign od[0] = {32'h0, od0};
    assign od[1] = {32'h0, od1};
    assign od[2] = od2;
    assign cnt[0] = 48'(c0);
    assign cnt[1] = 48'(c1);
    assign cnt[2] = 48'(c2);

    function automatic logic [47:0] wmask(input int k);
        return (k == 2) ? 48'hFFFF_FFFF_FFFF : 48'h0000_0000_FFFF;
    endfunction

    function automatic int nstages(input int k);
        return k + 1;
    endfunction

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic begin_dut();
        sb.delete();
        hold_pend = 0;
    endtask

    // One clock of traffic on DUT k: sample before the edge, update the
    // reference queue at the edge, then compare the held-beat count.
    task automatic cycle(input int k);
        logic        ov_s, rdy_s;
        logic [47:0] od_s;
        bit          acc, dr;
        @(negedge clk);
        ov_s  = ov[k];
        rdy_s = ordy[k];
        od_s  = od[k];
        if (hold_pend) begin
            chk("hold_valid", {47'h0, ov_s}, 48'h1);
            chk("hold_data", od_s, hold_data);
        end
        acc = v[k] & rdy_s & !fl[k];
        dr  = ov_s & r[k] & !fl[k];
        if (dr) begin
            if (sb.size() == 0) begin
                chk("extra_beat", {47'h0, ov_s}, 48'h0);
            end else begin
                chk("order", od_s, sb.pop_front());
                ndrained++;
            end
        end
        hold_pend = ov_s & !r[k] & !fl[k];
        hold_data = od_s;
        last_acc  = acc;
        @(posedge clk);
        #1;
        if (fl[k]) begin
            sb.delete();
        end
        if (acc) begin
            sb.push_back(din[k] & wmask(k));
        end
        chk("count", cnt[k], 48'(sb.size()));
    endtask

    task automatic idle_all();
        for (int k = 0; k < 3; k++) begin
            v[k] = 1'b0; r[k] = 1'b0; fl[k] = 1'b0; din[k] = '0;
        end
    endtask

    initial begin
        int acc_n;
        int d0;
        int idx;
        rst_n = 1'b0;
        idle_all();

        // Reset values on every configuration.
        #3;
        for (int k = 0; k < 3; k++) begin
            chk("rst_valid", {47'h0, ov[k]}, 48'h0);
            chk("rst_ready", {47'h0, ordy[k]}, 48'h1);
            chk("rst_data", od[k], 48'h0);
            chk("rst_count", cnt[k], 48'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Streaming through one stage with the sink always ready.
        begin_dut();
        r[0] = 1'b1; v[0] = 1'b1;
        din[0] = 48'h1122; cycle(0);
        chk("stream_v1", {47'h0, ov[0]}, 48'h1);
        chk("stream_d1", od[0], 48'h1122);
        chk("stream_c1", cnt[0], 48'h1);
        din[0] = 48'h3344; cycle(0);
        chk("stream_d2", od[0], 48'h3344);
        chk("stream_r2", {47'h0, ordy[0]}, 48'h1);
        chk("stream_c2", cnt[0], 48'h1);
        din[0] = 48'h5566; cycle(0);
        chk("stream_d3", od[0], 48'h5566);
        chk("stream_c3", cnt[0], 48'h1);
        v[0] = 1'b0; cycle(0);
        chk("stream_end_v", {47'h0, ov[0]}, 48'h0);
        chk("stream_drained", 48'(ndrained), 48'd3);

        // First-presentation latency through three stages.
        begin_dut();
        r[2] = 1'b1; v[2] = 1'b1; din[2] = 48'h1234_5678_9ABC;
        cycle(2);
        v[2] = 1'b0;
        chk("lat_t0", {47'h0, ov[2]}, 48'h0);
        cycle(2);
        chk("lat_t1", {47'h0, ov[2]}, 48'h0);
        cycle(2);
        chk("lat_t2_v", {47'h0, ov[2]}, 48'h1);
        chk("lat_t2_d", od[2], 48'h1234_5678_9ABC);
        cycle(2);
        chk("lat_done", cnt[2], 48'h0);

        // Back-pressure on two stages: six offers, four absorbed.
        begin_dut();
        r[1] = 1'b0; v[1] = 1'b1; idx = 0; acc_n = 0;
        for (int i = 0; i < 6; i++) begin
            din[1] = {32'h0, 8'(8'h10 + idx), 8'(8'hE0 + idx)};
            cycle(1);
            if (last_acc) begin
                idx++; acc_n++;
            end
        end
        chk("bp_accepted", 48'(acc_n), 48'd4);
        chk("bp_ready_low", {47'h0, ordy[1]}, 48'h0);
        chk("bp_count", cnt[1], 48'd4);
        v[1] = 1'b0; r[1] = 1'b1; d0 = ndrained;
        cycle(1);
        chk("bp_ready_after_drain1", {47'h0, ordy[1]}, 48'h0);
        cycle(1);
        chk("bp_ready_recovered", {47'h0, ordy[1]}, 48'h1);
        cycle(1);
        cycle(1);
        cycle(1);
        chk("bp_drained", 48'(ndrained - d0), 48'd4);
        chk("bp_empty", cnt[1], 48'h0);

        // Reset asserted mid-stream with two beats held.
        begin_dut();
        r[1] = 1'b0; v[1] = 1'b1;
        din[1] = 48'h0C0D; cycle(1);
        din[1] = 48'h0E0F; cycle(1);
        v[1] = 1'b0;
        chk("pre_rst_count", cnt[1], 48'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {47'h0, ov[1]}, 48'h0);
        chk("mid_rst_ready", {47'h0, ordy[1]}, 48'h1);
        chk("mid_rst_data", od[1], 48'h0);
        chk("mid_rst_count", cnt[1], 48'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        begin_dut();
        r[1] = 1'b1;
        cycle(1);
        chk("post_rst_valid", {47'h0, ov[1]}, 48'h0);

        // Flush with three beats held and a beat offered on the same cycle.
        begin_dut();
        r[1] = 1'b0; v[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din[1] = {32'h0, 16'(16'h0101 * (i + 1))};
            cycle(1);
        end
        chk("fl_pre_count", cnt[1], 48'd3);
        din[1] = 48'hAABB; fl[1] = 1'b1;
        cycle(1);
        fl[1] = 1'b0; v[1] = 1'b0;
        chk("fl_count", cnt[1], 48'h0);
        chk("fl_valid", {47'h0, ov[1]}, 48'h0);
        chk("fl_ready", {47'h0, ordy[1]}, 48'h1);
        r[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle(1);
            chk("fl_no_output", {47'h0, ov[1]}, 48'h0);
        end

        // Flush coinciding with a downstream handshake.
        begin_dut();
        r[1] = 1'b0; v[1] = 1'b1;
        din[1] = 48'h5A5A; cycle(1);
        din[1] = 48'hA5A5; cycle(1);
        v[1] = 1'b0;
        chk("fd_valid_before", {47'h0, ov[1]}, 48'h1);
        r[1] = 1'b1; fl[1] = 1'b1;
        cycle(1);
        fl[1] = 1'b0;
        chk("fd_count", cnt[1], 48'h0);
        chk("fd_valid", {47'h0, ov[1]}, 48'h0);
        for (int i = 0; i < 3; i++) begin
            cycle(1);
        end

        // Randomized traffic on every configuration.
        for (int k = 0; k < 3; k++) begin
            begin_dut();
            for (int n = 0; n < 10000; n++) begin
                v[k]   = ($urandom_range(0, 3) != 0);
                r[k]   = ($urandom_range(0, 2) != 0);
                fl[k]  = ($urandom_range(0, 299) == 0);
                din[k] = {$urandom, $urandom} & wmask(k);
                cycle(k);
            end
            v[k] = 1'b0; r[k] = 1'b1; fl[k] = 1'b0;
            for (int n = 0; n < 2 * nstages(k) + 2; n++) begin
                cycle(k);
            end
            chk("rand_final_count", cnt[k], 48'h0);
            idle_all();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
